// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared FSM state type and default word width for the serializer
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - one-entry word register with full flag, write and read strobes
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o
);

  // Capture a word on write; a read only drops the full flag, data is left as-is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_o <= '0;
      full_o  <= 1'b0;
    end else if (wr_i) begin
      rdata_o <= wdata_i;
      full_o  <= 1'b1;
    end else if (rd_i) begin
      full_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with one-word hold buffer
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             frame_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  piso_state_t      state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, cnt_n;
  logic             x_n, frame_n, last_n;
  logic             accept, load;
  logic [WIDTH-1:0] load_word;
  logic             hold_wr, hold_rd, hold_full, hold_full_n;
  logic [WIDTH-1:0] hold_data;

  // Bit that goes on the line first for a given register image.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the head position, zero-filling behind it.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept = valid_i & ready_o;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (hold_wr),
    .wdata_i (data_i),
    .rd_i    (hold_rd),
    .rdata_o (hold_data),
    .full_o  (hold_full)
  );

  // Next-state and next-output decode; a load (fresh, bypass or from hold) restarts a word.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = bit_cnt;
    x_n       = 1'b0;
    frame_n   = 1'b0;
    last_n    = 1'b0;
    hold_wr   = 1'b0;
    hold_rd   = 1'b0;
    load      = 1'b0;
    load_word = data_i;

    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_word = data_i;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_IDX) begin
          if (hold_full) begin
            load      = 1'b1;
            load_word = hold_data;
            hold_rd   = 1'b1;
          end else if (accept) begin
            // Accept on the last-bit edge with an empty hold goes straight in.
            load      = 1'b1;
            load_word = data_i;
          end else begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
          end
        end else begin
          hold_wr = accept;
          cnt_n   = bit_cnt + CW'(1);
          shreg_n = advance(shreg);
          x_n     = head_bit(shreg_n);
          frame_n = 1'b1;
          last_n  = (cnt_n == LAST_IDX);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (load) begin
      state_n = SHIFT;
      shreg_n = load_word;
      cnt_n   = '0;
      x_n     = head_bit(load_word);
      frame_n = 1'b1;
      last_n  = 1'b0;
    end
  end

  // Mirror of the hold flag's next value so ready/busy can be registered alongside it.
  always_comb begin
    hold_full_n = hold_full;
    if (hold_wr) begin
      hold_full_n = 1'b1;
    end else if (hold_rd) begin
      hold_full_n = 1'b0;
    end
  end

  // State, shift register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      x_o     <= 1'b0;
      frame_o <= 1'b0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= cnt_n;
      x_o     <= x_n;
      frame_o <= frame_n;
      last_o  <= last_n;
      busy_o  <= frame_n | hold_full_n;
      ready_o <= ~hold_full_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic       ready_m, x_m, frame_m, last_m, busy_m;
  logic       ready_l, x_l, frame_l, last_l, busy_l;
  logic [3:0] sr = 4'h0;
  int         total = 0;
  int         bad = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_m),
    .valid_i (valid_m),
    .ready_o (ready_m),
    .x_o     (x_m),
    .frame_o (frame_m),
    .last_o  (last_m),
    .busy_o  (busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_l),
    .valid_i (valid_l),
    .ready_o (ready_l),
    .x_o     (x_l),
    .frame_o (frame_l),
    .last_o  (last_l),
    .busy_o  (busy_l)
  );

  always #5 clk = ~clk;

  // Downstream serial-in shift register fed by the MSB-first instance.
  always @(posedge clk) begin
    if (frame_m) sr <= {sr[2:0], x_m};
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    valid_m = 1'b0; data_m = 4'h0;
    valid_l = 1'b0; data_l = 4'h0;
    #1 reset = 1'b0;
    #1;
    total++;
    if ({x_m, frame_m, last_m, busy_m, ready_m} !== 5'b00001)
      $display("FAIL reset_msb got=%b want=00001", {x_m, frame_m, last_m, busy_m, ready_m});
    total++;
    if ({x_l, frame_l, last_l, busy_l, ready_l} !== 5'b00001)
      $display("FAIL reset_lsb got=%b want=00001", {x_l, frame_l, last_l, busy_l, ready_l});
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({x_m, frame_m, last_m, busy_m, ready_m} !== 5'b00001)
      $display("FAIL reset_release got=%b want=00001", {x_m, frame_m, last_m, busy_m, ready_m});
  endtask

  // 4'b1011 MSB first, accepted on the first edge after reset release.
  task automatic test_basic();
    logic [3:0] w = 4'b1011;
    logic [4:0] exp;
    for (int c = 0; c <= 5; c++) begin
      valid_m = (c == 0);
      data_m  = (c == 0) ? w : 4'h0;
      @(negedge clk);
      exp[4] = (c >= 1 && c <= 4) ? w[4-c] : 1'b0;
      exp[3] = (c >= 1 && c <= 4);
      exp[2] = (c == 4);
      exp[1] = (c >= 1 && c <= 4);
      exp[0] = 1'b1;
      total++;
      if ({x_m, frame_m, last_m, busy_m, ready_m} !== exp) begin
        bad++;
        $display("FAIL basic c=%0d got=%b want=%b", c, {x_m, frame_m, last_m, busy_m, ready_m}, exp);
      end
      next_cycle();
    end
    total++;
    if (sr !== 4'b1011) begin
      bad++;
      $display("FAIL basic_sr got=%b want=1011", sr);
    end
  endtask

  // 4'hA then 4'h5; second word parks in the hold buffer; data_i junk afterwards.
  task automatic test_pair();
    logic [7:0] seq = 8'hA5;
    logic [4:0] exp;
    logic       full;
    for (int c = 0; c <= 9; c++) begin
      valid_m = (c <= 1);
      data_m  = (c == 0) ? 4'hA : (c == 1) ? 4'h5 : 4'hF;
      @(negedge clk);
      full   = (c >= 2 && c <= 4);
      exp[4] = (c >= 1 && c <= 8) ? seq[8-c] : 1'b0;
      exp[3] = (c >= 1 && c <= 8);
      exp[2] = (c == 4 || c == 8);
      exp[1] = exp[3] | full;
      exp[0] = ~full;
      total++;
      if ({x_m, frame_m, last_m, busy_m, ready_m} !== exp) begin
        bad++;
        $display("FAIL pair c=%0d got=%b want=%b", c, {x_m, frame_m, last_m, busy_m, ready_m}, exp);
      end
      next_cycle();
    end
  endtask

  // valid held high for 1,2,3; upstream advances only when ready was high.
  task automatic test_stream();
    logic [11:0] seq = 12'h123;
    logic [4:0]  exp;
    logic        full;
    for (int c = 0; c <= 13; c++) begin
      valid_m = (c <= 5);
      data_m  = (c == 0) ? 4'h1 : (c == 1) ? 4'h2 : (c <= 5) ? 4'h3 : 4'h0;
      @(negedge clk);
      full   = (c >= 2 && c <= 4) || (c >= 6 && c <= 8);
      exp[4] = (c >= 1 && c <= 12) ? seq[12-c] : 1'b0;
      exp[3] = (c >= 1 && c <= 12);
      exp[2] = (c == 4 || c == 8 || c == 12);
      exp[1] = exp[3] | full;
      exp[0] = ~full;
      total++;
      if ({x_m, frame_m, last_m, busy_m, ready_m} !== exp) begin
        bad++;
        $display("FAIL stream c=%0d got=%b want=%b", c, {x_m, frame_m, last_m, busy_m, ready_m}, exp);
      end
      next_cycle();
    end
  endtask

  // Second word offered only during the last-bit cycle: bypass load, no gap.
  task automatic test_bypass();
    logic [7:0] seq = 8'hC6;
    logic [4:0] exp;
    for (int c = 0; c <= 9; c++) begin
      valid_m = (c == 0 || c == 4);
      data_m  = (c == 0) ? 4'hC : (c == 4) ? 4'h6 : 4'h9;
      @(negedge clk);
      exp[4] = (c >= 1 && c <= 8) ? seq[8-c] : 1'b0;
      exp[3] = (c >= 1 && c <= 8);
      exp[2] = (c == 4 || c == 8);
      exp[1] = exp[3];
      exp[0] = 1'b1;
      total++;
      if ({x_m, frame_m, last_m, busy_m, ready_m} !== exp) begin
        bad++;
        $display("FAIL bypass c=%0d got=%b want=%b", c, {x_m, frame_m, last_m, busy_m, ready_m}, exp);
      end
      next_cycle();
    end
  endtask

  // Reset in cycle 2 of 4'hF with 4'h9 held; both discarded, then 4'h3 runs clean.
  task automatic test_reset_mid();
    logic [3:0] w = 4'h3;
    logic [4:0] exp;
    valid_m = 1'b1; data_m = 4'hF;
    next_cycle();
    valid_m = 1'b1; data_m = 4'h9;
    @(negedge clk);
    total++;
    if ({x_m, frame_m, ready_m} !== 3'b111) begin
      bad++;
      $display("FAIL rst_pre got=%b want=111", {x_m, frame_m, ready_m});
    end
    next_cycle();
    valid_m = 1'b0; data_m = 4'h0;
    reset = 1'b0;
    #1;
    total++;
    if ({x_m, frame_m, last_m, busy_m, ready_m} !== 5'b00001) begin
      bad++;
      $display("FAIL rst_async got=%b want=00001", {x_m, frame_m, last_m, busy_m, ready_m});
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      valid_m = (c == 0);
      data_m  = (c == 0) ? w : 4'h0;
      @(negedge clk);
      exp[4] = (c >= 1 && c <= 4) ? w[4-c] : 1'b0;
      exp[3] = (c >= 1 && c <= 4);
      exp[2] = (c == 4);
      exp[1] = (c >= 1 && c <= 4);
      exp[0] = 1'b1;
      total++;
      if ({x_m, frame_m, last_m, busy_m, ready_m} !== exp) begin
        bad++;
        $display("FAIL rst_after c=%0d got=%b want=%b", c, {x_m, frame_m, last_m, busy_m, ready_m}, exp);
      end
      next_cycle();
    end
  endtask

  // LSB-first instance: 4'b0001 comes out as 1,0,0,0.
  task automatic test_lsb_first();
    logic [3:0] bits = 4'b0001;
    logic [4:0] exp;
    for (int c = 0; c <= 5; c++) begin
      valid_l = (c == 0);
      data_l  = (c == 0) ? 4'b0001 : 4'hE;
      @(negedge clk);
      exp[4] = (c >= 1 && c <= 4) ? bits[c-1] : 1'b0;
      exp[3] = (c >= 1 && c <= 4);
      exp[2] = (c == 4);
      exp[1] = (c >= 1 && c <= 4);
      exp[0] = 1'b1;
      total++;
      if ({x_l, frame_l, last_l, busy_l, ready_l} !== exp) begin
        bad++;
        $display("FAIL lsb c=%0d got=%b want=%b", c, {x_l, frame_l, last_l, busy_l, ready_l}, exp);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pair();
    test_stream();
    test_bypass();
    test_reset_mid();
    test_lsb_first();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = data_i[WIDTH-1] sent first; 0 = data_i[0] sent first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_i, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port valid_i, input, 1 bit: data_i is valid this cycle.
REQ-007 SHALL have port ready_o, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port x_o, output, 1 bit: serial data line to the downstream serial-in shift register.
REQ-009 SHALL have port frame_o, output, 1 bit: x_o carries a valid data bit this cycle.
REQ-010 SHALL have port last_o, output, 1 bit: x_o carries the final bit of a word.
REQ-011 SHALL have port busy_o, output, 1 bit: a word is shifting or held.

Function
REQ-012 SHALL accept a word on a rising edge where valid_i=1 and ready_o=1; no other condition transfers data.
REQ-013 SHALL implement FSM states IDLE and SHIFT; the reset state is IDLE.
REQ-014 SHALL transition IDLE->SHIFT on accept: the word loads the shift register, bit_cnt=0, and the first bit appears on x_o the next cycle (latency 1).
REQ-015 SHALL present exactly one bit per cycle for WIDTH consecutive cycles in SHIFT, with frame_o=1 throughout.
REQ-016 SHALL assert last_o only when bit_cnt=WIDTH-1.
REQ-017 SHALL include a one-entry hold buffer, with ready_o = NOT hold_full, driven directly from a register.
REQ-018 SHALL, when a word is accepted in SHIFT, write it to the hold buffer, with one exception (REQ-019).
REQ-019 SHALL, when a word is accepted on the last-bit edge with the hold buffer empty, load it directly into the shift register (bypass) so that no idle gap occurs.
REQ-020 SHALL, at the end of the last bit with the hold buffer full, load from the hold buffer, clear hold_full, and stay in SHIFT with bit_cnt=0 (gap-free).
REQ-021 SHALL, at the end of the last bit with no held word and no accept, return to IDLE.
REQ-022 SHALL drive x_o=0, frame_o=0 and last_o=0 in IDLE.
REQ-023 SHALL compute busy_o = frame_o OR hold_full.
REQ-024 SHALL register all outputs (no combinational path from inputs to outputs).
REQ-025 SHALL ignore data_i while valid_i=0 or ready_o=0.
REQ-026 SHALL size bit_cnt as $clog2(WIDTH) bits and wrap it to 0 after WIDTH-1.

Reset
REQ-027 SHALL, on reset=0 asynchronously, force IDLE, bit_cnt=0, shift register=0, hold_full=0, x_o=0, frame_o=0, last_o=0, busy_o=0 and ready_o=1.
REQ-028 SHALL, on reset asserted mid-word, discard the partial word and any held word; no further bits are emitted.
REQ-029 SHALL allow acceptance on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take the FSM state enum (IDLE, SHIFT) from shared package piso_pkg, which also holds the WIDTH default constant.
REQ-031 SHALL implement the hold buffer as sub-module piso_hold_buf (one-entry register with full flag, write and read strobes).

Verification
REQ-032 SHALL cover: WIDTH=4, MSB_FIRST=1, 4'b1011 accepted at cycle 0 -> x_o=1,0,1,1 in cycles 1-4; last_o only in cycle 4; downstream shift register sr_o=4'b1011 after the 4th shift edge.
REQ-033 SHALL cover: 4'hA then 4'h5 accepted on consecutive opportunities -> frame_o high for 8 contiguous cycles, x_o=1,0,1,0,0,1,0,1.
REQ-034 SHALL cover: valid_i held at 1 with words 4'h1, 4'h2, 4'h3 -> ready_o=0 while the hold buffer is full; all three words are emitted in order with no gaps and none lost.
REQ-035 SHALL cover: accept during the last-bit cycle with the hold buffer empty -> the next word's first bit appears in the immediately following cycle.
REQ-036 SHALL cover: reset=0 in cycle 2 of word 4'hF -> all outputs 0 immediately, ready_o=1; word 4'h3 after release serializes correctly.
REQ-037 SHALL cover: MSB_FIRST=0, 4'b0001 -> x_o=1,0,0,0.
